// File: rtl/sub_result_queue.sv
// Result queue that sits behind the 8-bit subtractor. Each difference is
// buffered with its status flags, and results are handed on over valid/ready.
module sub_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               s,
    input  logic                     cout,
    input  logic                     a_msb,
    input  logic                     b_msb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_diff,
    output logic                     out_borrow,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         total,
    output logic                     ovf_sticky
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
        logic       neg;
        logic       ovf;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_nxt;
    logic               push;
    logic               pop;

    // Handshakes, push-time flag derivation and next occupancy
    always_comb begin
        push             = in_valid && in_ready;
        pop              = out_valid && out_ready;
        new_entry.diff   = s;
        new_entry.borrow = ~cout;
        new_entry.zero   = (s == 8'h00);
        new_entry.neg    = s[7];
        new_entry.ovf    = (a_msb != b_msb) && (s[7] != a_msb);
        level_nxt        = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    // Storage; clearing it on reset makes the head read zero during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy, status and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            total      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                total  <= total + CNT_W'(1);
                if (new_entry.ovf) begin
                    ovf_sticky <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level     <= level_nxt;
            in_ready  <= (level_nxt != LVL_W'(DEPTH));
            out_valid <= (level_nxt != LVL_W'(0));
        end
    end

    assign head       = mem[rd_ptr];
    assign out_diff   = head.diff;
    assign out_borrow = head.borrow;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_ovf    = head.ovf;

endmodule

// File: tb/tb_sub_result_queue.sv
// Directed bench for sub_result_queue: flags, ordering, full/backpressure,
// async reset and total counter wrap.
module tb_sub_result_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s;
    logic       cout;
    logic       a_msb;
    logic       b_msb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_diff;
    logic       out_borrow;
    logic       out_zero;
    logic       out_neg;
    logic       out_ovf;
    logic [2:0] level;
    logic [7:0] total;
    logic       ovf_sticky;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [5];

    sub_result_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s          (s),
        .cout       (cout),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .level      (level),
        .total      (total),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle push; returns #1 after the accepting edge with in_valid dropped
    task automatic push_one(input logic [7:0] d, input logic c, input logic am, input logic bm);
        @(negedge clk);
        s = d; cout = c; a_msb = am; b_msb = bm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s = 8'h00; cout = 1'b0; a_msb = 1'b0; b_msb = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_total", 32'(total), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_diff", 32'(out_diff), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // 0x0F - 0x01
        push_one(8'h0E, 1'b1, 1'b0, 1'b0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_diff", 32'(out_diff), 32'h0E);
        check("t1_flags", {28'd0, out_borrow, out_zero, out_neg, out_ovf}, 32'b0000);
        check("t1_total", 32'(total), 32'd1);
        @(posedge clk); #1;
        check("t1_drained", 32'(level), 32'd0);

        // 0x0F - 0x0F
        push_one(8'h00, 1'b1, 1'b0, 1'b0);
        check("t2_diff", 32'(out_diff), 32'h00);
        check("t2_flags", {28'd0, out_borrow, out_zero, out_neg, out_ovf}, 32'b0100);
        @(posedge clk); #1;

        // 0x00 - 0x01
        push_one(8'hFF, 1'b0, 1'b0, 1'b0);
        check("t3_diff", 32'(out_diff), 32'hFF);
        check("t3_flags", {28'd0, out_borrow, out_zero, out_neg, out_ovf}, 32'b1010);
        check("t3_sticky", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;

        // 0x80 - 0x01: signed overflow
        push_one(8'h7F, 1'b1, 1'b1, 1'b0);
        check("t4_diff", 32'(out_diff), 32'h7F);
        check("t4_flags", {28'd0, out_borrow, out_zero, out_neg, out_ovf}, 32'b0001);
        check("t4_sticky", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1;
        check("t4_level", 32'(level), 32'd0);
        check("t4_sticky_after_pop", 32'(ovf_sticky), 32'd1);
        check("t4_total", 32'(total), 32'd4);

        // Fill with backpressure, five results offered back to back
        exp_q[0] = 8'h10; exp_q[1] = 8'h11; exp_q[2] = 8'h12;
        exp_q[3] = 8'h13; exp_q[4] = 8'h14;
        @(negedge clk);
        out_ready = 1'b0;
        cout = 1'b1; a_msb = 1'b0; b_msb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            s = exp_q[k];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_total", 32'(total), 32'd8);
        check("full_head", 32'(out_diff), 32'h10);
        @(posedge clk); #1;
        check("full_hold_level", 32'(level), 32'd4);
        check("full_hold_total", 32'(total), 32'd8);
        check("full_hold_head", 32'(out_diff), 32'h10);

        // Drain in order; the held fifth result enters on the first free slot
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) out_ready = 1'b1;
            if (i == 2) in_valid = 1'b0;
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_order", 32'(out_diff), 32'(exp_q[i]));
            if (i == 1 || i == 2) check("drain_level", 32'(level), 32'd3);
        end
        @(posedge clk); #1;
        check("drain_empty", 32'(level), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_total", 32'(total), 32'd9);

        // Async reset with three entries queued
        out_ready = 1'b0;
        push_one(8'h21, 1'b1, 1'b0, 1'b0);
        push_one(8'h22, 1'b1, 1'b0, 1'b0);
        push_one(8'h23, 1'b1, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_total", 32'(total), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_sticky", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_one(8'h55, 1'b0, 1'b0, 1'b1);
        check("post_rst_head", 32'(out_diff), 32'h55);
        check("post_rst_flags", {28'd0, out_borrow, out_zero, out_neg, out_ovf}, 32'b1000);
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_total", 32'(total), 32'd1);

        // Stream 255 more results through to roll total over
        @(negedge clk);
        out_ready = 1'b1;
        s = 8'h01; cout = 1'b1; a_msb = 1'b0; b_msb = 1'b0;
        in_valid = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        check("wrap_total", 32'(total), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("wrap_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_result_queue.md
Name: sub_result_queue

Overview:
- Downstream stage of the 8-bit subtractor: captures each difference S and carry-out Cout, derives status flags, and buffers the results in a small FIFO.
- Hands results to the consumer over a valid/ready handshake.
- Decouples the combinational subtractor from a slower consumer, such as a display or serial reporter.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, range 2..16.
- CNT_W, 8, width of the total-results counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  subtractor result present this cycle.
- in_ready  output  1  queue can accept a result.
- s  input  8  difference from the subtractor (A + ~B + 1).
- cout  input  1  subtractor carry-out; 1 = no borrow.
- a_msb  input  1  bit 7 of operand A for this result.
- b_msb  input  1  bit 7 of operand B for this result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_diff  output  8  head difference.
- out_borrow  output  1  head borrow, equal to ~cout.
- out_zero  output  1  head difference == 0.
- out_neg  output  1  head difference bit 7.
- out_ovf  output  1  head signed overflow.
- level  output  clog2(DEPTH)+1  current occupancy.
- total  output  CNT_W  results accepted since reset; wraps modulo 2^CNT_W.
- ovf_sticky  output  1  set when any accepted result has ovf=1; cleared only by rst.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, in_ready=1, total=0, ovf_sticky=0.
  - out_diff and the flag outputs read 0 during reset; their value is don't-care while out_valid=0.
  - Asserting reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Push: occurs when in_valid && in_ready at a rising edge. The entry {s, ~cout, s==0, s[7], ovf} is written at wr_ptr, then wr_ptr increments modulo DEPTH and total increments with wrap.
  - Signed overflow: ovf = (a_msb != b_msb) && (s[7] != a_msb).
  - Flags are computed at push time, not on the output side.
- Pop: occurs when out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- Status signals:
  - in_ready = (level != DEPTH), combinational from registered state only. It does not depend on out_ready, so there is no through-path.
  - out_valid = (level != 0).
- Output path: out_* are driven from the entry at rd_ptr. Latency is 1 cycle: a push into an empty queue gives out_valid=1 on the following cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance.
  - When full, no push is possible (in_ready=0), so only the pop takes effect.
  - When empty, no pop is possible (out_valid=0), so only the push takes effect.
- Ignored inputs:
  - in_valid while in_ready=0 is ignored; the upstream stage must hold its data.
  - out_ready while out_valid=0 is ignored.
- Output stability: out_diff and the flags hold stable while out_valid=1 && out_ready=0.
- Pointer wrap: pointers wrap from DEPTH-1 to 0; level distinguishes full from empty.
- Counters: total rolls over from 2^CNT_W-1 to 0 with no flag. ovf_sticky is set on the push edge of an ovf entry.
- Internal state: no state machine beyond the FIFO pointers and counters. The full/empty condition is fully determined by level.

Test Plan:
- Push s=0x0E, cout=1, a_msb=0, b_msb=0 (computing 0x0F-0x01), out_ready=1 -> next cycle out_valid=1, out_diff=0x0E, borrow=0, zero=0, neg=0, ovf=0; total=1.
- Push s=0x00, cout=1, a_msb=0, b_msb=0 (computing 0x0F-0x0F) -> out_zero=1, borrow=0, neg=0.
- Push s=0xFF, cout=0, a_msb=0, b_msb=0 (computing 0x00-0x01) -> borrow=1, neg=1, ovf=0.
- Push s=0x7F, cout=1, a_msb=1, b_msb=0 (computing 0x80-0x01) -> ovf=1, neg=0, ovf_sticky=1 and it stays 1 after the pop.
- Hold out_ready=0 and push 5 results with in_valid held high:
  - after the 4th accepted push: level=4, in_ready=0.
  - the 5th result is held until the pop;
  - then drain with out_ready=1 -> results appear in push order and level ends at 0.
- With level=3, assert rst between clock edges -> out_valid=0, level=0, total=0, in_ready=1 immediately. The first post-reset push appears at the head.
